// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle processor control unit:
// state encoding, opcode values and datapath select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    ADDIEX = 4'd8,
    ADDIWB = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    HALT   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Where DECODE dispatches each opcode; FETCH doubles as "unsupported".
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_RTYPE:     return EXEC;
      OP_ADDI:      return ADDIEX;
      OP_LW, OP_SW: return MEMADR;
      OP_BEQ:       return BRANCH;
      OP_J:         return JUMP;
      OP_HALT:      return HALT;
      default:      return FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State-to-datapath-control decoder. All outputs are forced low while
// 'active' is low so the controller is silent during reset.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  logic       active,
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic [5:0] opcode,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       halted
);

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_REGB;
    aluop       = ALUOP_ADD;
    pcsrc       = PCSRC_ALU;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    if (active) begin
      case (state_t'(state))
        FETCH: begin
          memread = 1'b1;
          alusrcb = SRCB_FOUR;
          irwrite = mem_ready;
          pcwrite = mem_ready;
        end
        DECODE: begin
          alusrcb    = SRCB_IMMSH;
          illegal_op = (decode_next(opcode) == FETCH);
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        MEMRD: begin
          memread = 1'b1;
          iord    = 1'b1;
        end
        MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        // A store retires in the cycle memory accepts it.
        MEMWR: begin
          memwrite   = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        RWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
        end
        ADDIWB: begin
          regwrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          alusrca     = 1'b1;
          aluop       = ALUOP_SUB;
          pcwritecond = 1'b1;
          pcsrc       = PCSRC_ALUOUT;
          instr_done  = 1'b1;
        end
        JUMP: begin
          pcwrite    = 1'b1;
          pcsrc      = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: state register and sequencing here,
// output decoding delegated to mc_ctrl_outdec.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       halted,
  output logic [3:0] state
);

  state_t cur_state, next_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cur_state <= FETCH;
    else          cur_state <= next_state;
  end

  // Memory states wait on mem_ready; all others advance unconditionally.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      FETCH:  if (mem_ready) next_state = DECODE;
      DECODE: next_state = decode_next(opcode);
      MEMADR: next_state = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  if (mem_ready) next_state = MEMWB;
      MEMWR:  if (mem_ready) next_state = FETCH;
      EXEC:   next_state = RWB;
      ADDIEX: next_state = ADDIWB;
      MEMWB, RWB, ADDIWB, BRANCH, JUMP: next_state = FETCH;
      HALT:   next_state = HALT;
      default: next_state = FETCH;
    endcase
  end

  assign state = cur_state;

  mc_ctrl_outdec u_outdec (
    .active      (reset_n),
    .state       (cur_state),
    .mem_ready   (mem_ready),
    .opcode      (opcode),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsrc       (pcsrc),
    .instr_done  (instr_done),
    .illegal_op  (illegal_op),
    .halted      (halted)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: each instruction is expanded into a list of
// phases, memory phases are stretched by wait cycles, and every cycle is checked.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic       instr_done, illegal_op, halted;
  logic [3:0] state;

  int compared   = 0;
  int mismatched = 0;
  state_t plan[$];

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .instr_done(instr_done), .illegal_op(illegal_op), .halted(halted),
    .state(state)
  );

  always #5 clk = ~clk;

  logic [18:0] obsVec;
  assign obsVec = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                   memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
                   instr_done, illegal_op, halted};

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT};
  endfunction

  function automatic bit isMemPhase(input state_t p);
    return (p == FETCH) || (p == MEMRD) || (p == MEMWR);
  endfunction

  // Control word each phase must present, straight from the instruction table.
  function automatic logic [18:0] expOut(input state_t p, input logic mr, input logic [5:0] op);
    logic pw = 0, pwc = 0, ior = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0, rw = 0, asa = 0;
    logic idone = 0, ill = 0, hlt = 0;
    logic [1:0] asb = 2'b00, aop = 2'b00, psrc = 2'b00;
    case (p)
      FETCH:  begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      DECODE: begin asb = 2'b11; ill = !isLegal(op); end
      MEMADR: begin asa = 1; asb = 2'b10; end
      MEMRD:  begin mrd = 1; ior = 1; end
      MEMWB:  begin m2r = 1; rw = 1; idone = 1; end
      MEMWR:  begin mwr = 1; ior = 1; idone = mr; end
      EXEC:   begin asa = 1; aop = 2'b10; end
      RWB:    begin rd = 1; rw = 1; idone = 1; end
      ADDIEX: begin asa = 1; asb = 2'b10; end
      ADDIWB: begin rw = 1; idone = 1; end
      BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; idone = 1; end
      JUMP:   begin pw = 1; psrc = 2'b10; idone = 1; end
      HALT:   hlt = 1;
      default: ;
    endcase
    return {pw, pwc, ior, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc, idone, ill, hlt};
  endfunction

  task automatic buildPlan(input logic [5:0] op);
    plan.delete();
    plan.push_back(FETCH);
    plan.push_back(DECODE);
    case (op)
      OP_RTYPE: begin plan.push_back(EXEC);   plan.push_back(RWB);    end
      OP_ADDI:  begin plan.push_back(ADDIEX); plan.push_back(ADDIWB); end
      OP_LW:    begin plan.push_back(MEMADR); plan.push_back(MEMRD); plan.push_back(MEMWB); end
      OP_SW:    begin plan.push_back(MEMADR); plan.push_back(MEMWR); end
      OP_BEQ:   plan.push_back(BRANCH);
      OP_J:     plan.push_back(JUMP);
      OP_HALT:  plan.push_back(HALT);
      default:  ;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic mr);
    @(negedge clk);
    opcode    = op;
    mem_ready = mr;
    #2;
  endtask

  // Pull reset low between edges and confirm the effect is immediate.
  task automatic assertResetAsync();
    #1 reset_n = 1'b0;
    #1;
    checkOutput("arst_state", 32'(state), 32'(FETCH));
    checkOutput("arst_outputs", 32'(obsVec), 32'd0);
  endtask

  // Hold reset across one edge, then release just after it.
  task automatic releaseReset();
    @(posedge clk);
    #1;
    checkOutput("rst_hold_state", 32'(state), 32'(FETCH));
    checkOutput("rst_hold_outputs", 32'(obsVec), 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic runInstr(input logic [5:0] op, input int fetchWaits, input int memWaits,
                          input bit resetInMemrd);
    int fw = fetchWaits;
    int mw = memWaits;
    int doneCount = 0;
    int haltCycles = 0;
    int expDone = (isLegal(op) && op != OP_HALT) ? 1 : 0;
    state_t ph;
    logic mr;
    buildPlan(op);
    while (plan.size() > 0) begin
      ph = plan[0];
      if (ph == FETCH)                    mr = (fw == 0);
      else if (ph == MEMRD || ph == MEMWR) mr = (mw == 0);
      else                                mr = 1'($urandom_range(0, 1));
      applyStimulus(op, mr);
      checkOutput($sformatf("state_%s", ph.name()), 32'(state), 32'(ph));
      checkOutput($sformatf("outputs_%s", ph.name()), 32'(obsVec), 32'(expOut(ph, mr, op)));
      checkOutput("exclusive", {30'd0, memread & memwrite, regwrite & memwrite}, 32'd0);
      doneCount += int'(instr_done);
      if (resetInMemrd && ph == MEMRD) begin
        assertResetAsync();
        plan.delete();
        return;
      end
      if (ph == HALT) begin
        haltCycles++;
        if (haltCycles == 20) plan.delete();
      end else if (isMemPhase(ph) && !mr) begin
        if (ph == FETCH) fw--;
        else             mw--;
      end else begin
        void'(plan.pop_front());
      end
    end
    checkOutput("done_count", doneCount, expDone);
  endtask

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    ops[0] = OP_RTYPE; ops[1] = OP_ADDI; ops[2] = OP_LW;
    ops[3] = OP_SW;    ops[4] = OP_BEQ;  ops[5] = OP_J;

    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = OP_LW;
    #3;
    checkOutput("reset_state", 32'(state), 32'(FETCH));
    checkOutput("reset_outputs", 32'(obsVec), 32'd0);
    releaseReset();

    $display("[TB] lw and sw with memory waits");
    runInstr(OP_LW, 0, 0, 0);
    runInstr(OP_SW, 0, 3, 0);

    $display("[TB] back-to-back R-type, addi, beq, j");
    runInstr(OP_RTYPE, 0, 0, 0);
    runInstr(OP_ADDI, 0, 0, 0);
    runInstr(OP_BEQ, 0, 0, 0);
    runInstr(OP_J, 0, 0, 0);

    $display("[TB] unsupported opcode");
    runInstr(6'b110000, 0, 0, 0);

    $display("[TB] asynchronous reset during MEMRD");
    runInstr(OP_LW, 1, 4, 1);
    releaseReset();

    $display("[TB] halt and reset recovery");
    runInstr(OP_HALT, 0, 0, 0);
    assertResetAsync();
    releaseReset();

    $display("[TB] randomized instruction stream");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        if (op == OP_HALT) op = 6'b110000;
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      runInstr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
